// File: rtl/sd_reg_file.sv
// sd_reg_file: bus-accessible register file with a core-side write port.
// Bus transactions complete one cycle after they are sampled (ack, err,
// data_out registered); the core port writes directly and loses to a
// successful bus write aimed at the same register in the same cycle.
module sd_reg_file #(
  parameter int                        DATA_WIDTH  = 8,
  parameter int                        ADDR_WIDTH  = 8,
  parameter int                        DEPTH       = 256,
  parameter int                        RO_COUNT    = 0,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  wnr,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ack,
  output logic                  err,
  input  logic                  hw_we,
  input  logic [ADDR_WIDTH-1:0] hw_addr,
  input  logic [DATA_WIDTH-1:0] hw_data,
  output logic                  collision
);

  // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
  typedef logic [ADDR_WIDTH:0] ext_t;

  localparam ext_t DEPTH_L = ext_t'(DEPTH);
  localparam ext_t RO_L    = ext_t'(RO_COUNT);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  logic                  bus_in_range;
  logic                  bus_ro;
  logic                  bus_wr_ok;
  logic                  bus_rd_ok;
  logic                  bus_err;
  logic                  hw_ok;
  logic                  hw_lost;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  vld_p1;
  logic                  err_p1;
  logic                  collision_p1;
  logic [DATA_WIDTH-1:0] data_out_p1;

  // True when the address selects an implemented register.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return ext_t'(a) < DEPTH_L;
  endfunction

  // Address decode of the bus request.
  assign bus_in_range = addr_in_range(address);

  // The low RO_COUNT registers are protected from bus writes only.
  generate
    if (RO_COUNT > 0) begin : g_ro
      assign bus_ro = ext_t'(address) < RO_L;
    end else begin : g_no_ro
      assign bus_ro = 1'b0;
    end
  endgenerate

  assign bus_wr_ok = req & wnr & bus_in_range & ~bus_ro;
  assign bus_rd_ok = req & ~wnr & bus_in_range;
  assign bus_err   = req & (~bus_in_range | (wnr & bus_ro));

  // Out-of-range core writes are dropped without any indication.
  assign hw_ok   = hw_we & addr_in_range(hw_addr);
  // Core write loses only to a bus write that actually lands.
  assign hw_lost = hw_ok & bus_wr_ok & (hw_addr == address);

  // Read mux: value of the addressed register before this edge's writes.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (address == ADDR_WIDTH'(i)) begin
        rd_data = regs[i];
      end
    end
  end

  // Register array: bus write has priority over core write on the same entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus_wr_ok && (address == ADDR_WIDTH'(i))) begin
          regs[i] <= data_in;
        end else if (hw_ok && (hw_addr == ADDR_WIDTH'(i))) begin
          regs[i] <= hw_data;
        end
      end
    end
  end

  // ---- stage p1: registered completion of the transaction sampled at this edge
  // Response register: ack/err/data_out/collision valid for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1       <= 1'b0;
      err_p1       <= 1'b0;
      collision_p1 <= 1'b0;
      data_out_p1  <= '0;
    end else begin
      vld_p1       <= req;
      err_p1       <= bus_err;
      collision_p1 <= hw_lost;
      data_out_p1  <= bus_rd_ok ? rd_data : '0;
    end
  end

  assign ack       = vld_p1;
  assign err       = err_p1;
  assign collision = collision_p1;
  assign data_out  = data_out_p1;

endmodule

// File: tb/tb_sd_reg_file.sv
// Directed bench for sd_reg_file: one default instance and one with
// DEPTH=16, RO_COUNT=4, RESET_VALUE=0xC3, sharing clock and bus fields.
module tb_sd_reg_file;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b;
  logic       wnr;
  logic [7:0] address, data_in;
  logic       hw_we_a, hw_we_b;
  logic [7:0] hw_addr, hw_data;

  logic [7:0] data_out_a, data_out_b;
  logic       ack_a, ack_b, err_a, err_b, collision_a, collision_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_reg_file dut_a (
    .clk(clk), .reset(reset), .req(req_a), .wnr(wnr), .address(address),
    .data_in(data_in), .data_out(data_out_a), .ack(ack_a), .err(err_a),
    .hw_we(hw_we_a), .hw_addr(hw_addr), .hw_data(hw_data),
    .collision(collision_a)
  );

  sd_reg_file #(.DEPTH(16), .RO_COUNT(4), .RESET_VALUE(8'hC3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .wnr(wnr), .address(address),
    .data_in(data_in), .data_out(data_out_b), .ack(ack_b), .err(err_b),
    .hw_we(hw_we_b), .hw_addr(hw_addr), .hw_data(hw_data),
    .collision(collision_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle, let the edge sample it, then settle past the edge.
  task automatic step(input logic ra, input logic rb, input logic w,
                      input logic [7:0] a, input logic [7:0] d);
    req_a = ra; req_b = rb; wnr = w; address = a; data_in = d;
    @(posedge clk);
    #1;
    hw_we_a = 1'b0; hw_we_b = 1'b0;
  endtask

  task automatic resp_a(input string tag, input logic k, input logic e, input logic [7:0] d);
    check({tag, ".ack"}, 32'(ack_a), 32'(k));
    check({tag, ".err"}, 32'(err_a), 32'(e));
    check({tag, ".dout"}, 32'(data_out_a), 32'(d));
  endtask

  task automatic resp_b(input string tag, input logic k, input logic e, input logic [7:0] d);
    check({tag, ".ack"}, 32'(ack_b), 32'(k));
    check({tag, ".err"}, 32'(err_b), 32'(e));
    check({tag, ".dout"}, 32'(data_out_b), 32'(d));
  endtask

  initial begin
    reset = 1'b0; req_a = 0; req_b = 0; wnr = 0; address = 0; data_in = 0;
    hw_we_a = 0; hw_we_b = 0; hw_addr = 0; hw_data = 0;

    // Reset state
    #12;
    resp_a("rst_a", 0, 0, 8'h00);
    check("rst_a.coll", 32'(collision_a), 32'd0);
    resp_b("rst_b", 0, 0, 8'h00);
    check("rst_b.coll", 32'(collision_b), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fill 0..255 back to back; first edge after release is accepted
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 1, 8'(i), 8'h05);
      resp_a($sformatf("fill%0d", i), 1, 0, 8'h00);
    end
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 8'(i), 8'h00);
      resp_a($sformatf("rdbk%0d", i), 1, 0, 8'h05);
    end

    // Idle cycle
    step(0, 0, 0, 8'd3, 8'h00);
    resp_a("idle", 0, 0, 8'h00);

    // Write then immediate read of the same address
    step(1, 0, 1, 8'd9, 8'h5A);
    resp_a("w9", 1, 0, 8'h00);
    step(1, 0, 0, 8'd9, 8'h00);
    resp_a("r9", 1, 0, 8'h5A);

    // Same-address bus/core write: bus wins, collision pulses once
    hw_we_a = 1; hw_addr = 8'd7; hw_data = 8'h22;
    step(1, 0, 1, 8'd7, 8'h11);
    resp_a("coll_w", 1, 0, 8'h00);
    check("coll_pulse", 32'(collision_a), 32'd1);
    step(1, 0, 0, 8'd7, 8'h00);
    resp_a("coll_r", 1, 0, 8'h11);
    check("coll_clear", 32'(collision_a), 32'd0);

    // Different addresses: both land, no collision
    hw_we_a = 1; hw_addr = 8'd11; hw_data = 8'h44;
    step(1, 0, 1, 8'd10, 8'h33);
    check("nocoll", 32'(collision_a), 32'd0);
    step(1, 0, 0, 8'd10, 8'h00);
    resp_a("r10", 1, 0, 8'h33);
    step(1, 0, 0, 8'd11, 8'h00);
    resp_a("r11", 1, 0, 8'h44);

    // Read concurrent with core write returns old value, next read new
    hw_we_a = 1; hw_addr = 8'd12; hw_data = 8'h77;
    step(1, 0, 0, 8'd12, 8'h00);
    resp_a("r12_old", 1, 0, 8'h05);
    step(1, 0, 0, 8'd12, 8'h00);
    resp_a("r12_new", 1, 0, 8'h77);
    step(0, 0, 0, 8'd0, 8'h00);

    // Instance B: reset value, out-of-range accesses
    step(0, 1, 0, 8'd3, 8'h00);
    resp_b("b_r3", 1, 0, 8'hC3);
    step(0, 1, 0, 8'd16, 8'h00);
    resp_b("b_r16", 1, 1, 8'h00);
    step(0, 1, 1, 8'd200, 8'hFF);
    resp_b("b_w200", 1, 1, 8'h00);
    step(0, 1, 0, 8'd8, 8'h00);
    resp_b("b_r8", 1, 0, 8'hC3);
    step(0, 1, 0, 8'd15, 8'h00);
    resp_b("b_r15", 1, 0, 8'hC3);
    step(0, 0, 0, 8'd0, 8'h00);
    resp_b("b_idle", 0, 0, 8'h00);

    // Read-only register: core writes it, bus write refused
    hw_we_b = 1; hw_addr = 8'd2; hw_data = 8'hA5;
    step(0, 0, 0, 8'd0, 8'h00);
    step(0, 1, 1, 8'd2, 8'h3C);
    resp_b("b_w2ro", 1, 1, 8'h00);
    step(0, 1, 0, 8'd2, 8'h00);
    resp_b("b_r2", 1, 0, 8'hA5);

    // Refused bus write does not block a core write to the same RO address
    hw_we_b = 1; hw_addr = 8'd3; hw_data = 8'h66;
    step(0, 1, 1, 8'd3, 8'h99);
    resp_b("b_w3ro", 1, 1, 8'h00);
    check("b_nocoll", 32'(collision_b), 32'd0);
    step(0, 1, 0, 8'd3, 8'h00);
    resp_b("b_r3hw", 1, 0, 8'h66);

    // Out-of-range core write ignored; first writable address accepts bus
    hw_we_b = 1; hw_addr = 8'd20; hw_data = 8'h99;
    step(0, 0, 0, 8'd0, 8'h00);
    step(0, 1, 0, 8'd4, 8'h00);
    resp_b("b_r4", 1, 0, 8'hC3);
    step(0, 1, 1, 8'd4, 8'h44);
    resp_b("b_w4", 1, 0, 8'h00);
    step(0, 1, 0, 8'd4, 8'h00);
    resp_b("b_r4new", 1, 0, 8'h44);

    // Reset mid-stream with req held high
    step(1, 1, 0, 8'd9, 8'h00);
    resp_a("pre_rst", 1, 0, 8'h5A);
    #2 reset = 1'b0;
    #1;
    resp_a("async_rst_a", 0, 0, 8'h00);
    resp_b("async_rst_b", 0, 0, 8'h00);
    @(posedge clk);
    #1;
    resp_a("in_rst_a", 0, 0, 8'h00);
    req_a = 0; req_b = 0;
    #3 reset = 1'b1;
    step(0, 0, 0, 8'd0, 8'h00);
    resp_a("post_rst", 0, 0, 8'h00);
    step(1, 1, 0, 8'd9, 8'h00);
    resp_a("rst_r9", 1, 0, 8'h00);
    step(1, 1, 0, 8'd7, 8'h00);
    resp_a("rst_r7", 1, 0, 8'h00);
    step(1, 1, 0, 8'd255, 8'h00);
    resp_a("rst_r255", 1, 0, 8'h00);
    step(0, 1, 0, 8'd2, 8'h00);
    resp_b("rst_b_r2", 1, 0, 8'hC3);
    step(0, 1, 0, 8'd4, 8'h00);
    resp_b("rst_b_r4", 1, 0, 8'hC3);
    step(0, 0, 0, 8'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_reg_file.md
SD_REG_FILE -- requirements
Module: sd_reg_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, register and bus data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, bus and hardware address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of implemented registers, 1..2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter RO_COUNT, default 0, number of registers at addresses 0..RO_COUNT-1 that are read-only from the bus.
REQ-005 The block SHALL have parameter RESET_VALUE, default 0, DATA_WIDTH-bit reset value of every register.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-009 The block SHALL have port req, input, 1, bus transaction request, one transaction per cycle while high.
REQ-010 The block SHALL have port wnr, input, 1, 1 = write and 0 = read, qualified by req.
REQ-011 The block SHALL have port address, input, ADDR_WIDTH, bus register address.
REQ-012 The block SHALL have port data_in, input, DATA_WIDTH, bus write data.
REQ-013 The block SHALL have port data_out, output, DATA_WIDTH, registered read data, valid with ack.
REQ-014 The block SHALL have port ack, output, 1, one-cycle completion pulse per accepted transaction.
REQ-015 The block SHALL have port err, output, 1, error flag, valid with ack.
REQ-016 The block SHALL have port hw_we, input, 1, core-side write strobe.
REQ-017 The block SHALL have port hw_addr, input, ADDR_WIDTH, core-side write address.
REQ-018 The block SHALL have port hw_data, input, DATA_WIDTH, core-side write data.
REQ-019 The block SHALL have port collision, output, 1, pulse when a hw write is dropped in favour of a bus write.

Function
REQ-020 The block SHALL sample req, wnr, address and data_in on every rising clk edge; req=1 at edge N is a transaction.
REQ-021 The block SHALL assert ack for exactly one cycle after edge N+1 for each transaction; back-to-back req SHALL give ack continuously high (throughput 1/cycle).
REQ-022 The block SHALL, for a bus write to address < DEPTH and >= RO_COUNT, update the register at edge N with data_in, err=0, data_out=0.
REQ-023 The block SHALL, for a bus read to address < DEPTH, present the register value as of before edge N on data_out with ack, err=0.
REQ-024 The block SHALL, for any bus access with address >= DEPTH, change no register, return data_out=0 and err=1.
REQ-025 The block SHALL, for a bus write to address < RO_COUNT, change no register and return err=1, data_out=0; bus reads of these addresses SHALL succeed.
REQ-026 The block SHALL, on hw_we=1 with hw_addr < DEPTH, write hw_data at that edge to any register, including read-only ones; hw_addr >= DEPTH SHALL be ignored silently.
REQ-027 The block SHALL, when a successful bus write and hw_we target the same address in the same cycle, keep the bus data, drop hw_data and pulse collision one cycle later; different addresses SHALL both write.
REQ-028 The block SHALL, for a bus read and hw write to the same address in the same cycle, return the old value; a read at edge N+1 SHALL see the new value.
REQ-029 The block SHALL, for a bus write at edge N followed by a bus read of the same address at N+1, return the written data.
REQ-030 The block SHALL drive data_out=0 and err=0 whenever ack=0.
REQ-031 The block SHALL treat req=0 cycles as idle: no register change from the bus, ack=0.

Reset
REQ-032 The block SHALL, while reset=0, asynchronously force all registers to RESET_VALUE and ack, err, collision, data_out to 0.
REQ-033 The block SHALL discard any transaction in flight when reset asserts; no ack SHALL follow it after release.
REQ-034 The block SHALL accept a transaction at the first rising edge after reset deasserts.

Verification
REQ-035 Defaults; write 0x05 to addresses 0..255 with req held high and wnr=1 -> ack high from the second cycle for 256 cycles, err=0; readback of all addresses returns 0x05.
REQ-036 DEPTH=16: read address 16 and write address 200 -> ack with err=1, data_out=0; registers unchanged.
REQ-037 RO_COUNT=4: hw write 0xA5 to address 2, bus write 0x3C to address 2 -> err=1; bus read of address 2 returns 0xA5.
REQ-038 Same-cycle bus write 0x11 and hw write 0x22 to address 7 -> collision pulses one cycle; read of address 7 returns 0x11.
REQ-039 Write 0x5A to address 9 at edge N, read address 9 at N+1 -> data_out=0x5A with ack, err=0.
REQ-040 Assert reset mid-stream with req high -> ack, err, data_out at 0 immediately; all registers read RESET_VALUE after release.
